// File: rtl/audio_serial_tx.sv
`default_nettype none
// ============================================================================
// Module   : audio_serial_tx
// Brief    : Bus-written sample FIFO drained one sample per request edge onto
//            a framed MSB-first serial link (sclk/sdata/sfs).
// Revision : 1.0  initial release
// ============================================================================
module audio_serial_tx #(
   parameter int DEPTH    = 16,
   parameter int SAMPLE_W = 16,
   parameter int CLK_DIV  = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wd,
   output logic [31:0] rd,
   input  logic        request,
   output logic        sclk,
   output logic        sdata,
   output logic        sfs,
   output logic        busy
);

   localparam int c_AW   = $clog2(DEPTH);
   localparam int c_CW   = c_AW + 1;
   localparam int c_DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int c_BW   = (SAMPLE_W > 1) ? $clog2(SAMPLE_W) : 1;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   logic [SAMPLE_W-1:0] r_mem [DEPTH];
   logic [c_AW-1:0]     r_wr_ptr, r_rd_ptr;
   logic [c_CW-1:0]     r_count;
   logic                r_enable, r_overflow, r_underrun;
   logic                r_s1, r_s2, r_s3;
   state_t              r_state, w_state_nx;
   logic [SAMPLE_W-1:0] r_shreg, w_shreg_nx;
   logic [c_DIVW-1:0]   r_div_cnt, w_div_nx;
   logic [c_BW-1:0]     r_bit_cnt, w_bit_nx;
   logic                r_sclk, r_sdata, r_sfs, r_busy;
   logic                w_sclk_nx, w_sdata_nx, w_sfs_nx, w_busy_nx;
   logic [31:0]         r_rd, w_rd_nx;

   logic [1:0]          w_sel;
   logic                w_push, w_stat_wr, w_ctrl_wr;
   logic                w_empty, w_full, w_edge;
   logic                w_pop, w_urun_set, w_push_ok, w_ovf_set;
   logic [SAMPLE_W-1:0] w_head;
   logic                w_unused;

   assign w_sel      = addr[3:2];
   assign w_push     = we && (w_sel == 2'd0);
   assign w_stat_wr  = we && (w_sel == 2'd1);
   assign w_ctrl_wr  = we && (w_sel == 2'd2);
   assign w_empty    = (r_count == '0);
   assign w_full     = (r_count == c_CW'(DEPTH));
   assign w_edge     = r_s2 & ~r_s3;
   assign w_head     = r_mem[r_rd_ptr];
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign w_push_ok  = w_push && (!w_full || w_pop);
   assign w_ovf_set  = w_push && w_full && !w_pop;
   assign w_unused   = ^{addr[31:4], addr[1:0], wd};

   assign rd    = r_rd;
   assign sclk  = r_sclk;
   assign sdata = r_sdata;
   assign sfs   = r_sfs;
   assign busy  = r_busy;

   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= wd[SAMPLE_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_enable   <= 1'b0;
         r_overflow <= 1'b0;
         r_underrun <= 1'b0;
         r_s1       <= 1'b0;
         r_s2       <= 1'b0;
         r_s3       <= 1'b0;
         r_rd       <= '0;
      end else begin
         r_s1 <= request;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
         r_rd <= w_rd_nx;
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_AW'(1);
         if (w_pop)     r_rd_ptr <= r_rd_ptr + c_AW'(1);
         case ({w_push_ok, w_pop})
            2'b10:   r_count <= r_count + c_CW'(1);
            2'b01:   r_count <= r_count - c_CW'(1);
            default: r_count <= r_count;
         endcase
         if (w_ctrl_wr) r_enable <= wd[0];
         // Set takes priority over a simultaneous software clear.
         if (w_ovf_set)                r_overflow <= 1'b1;
         else if (w_stat_wr && wd[2])  r_overflow <= 1'b0;
         if (w_urun_set)               r_underrun <= 1'b1;
         else if (w_stat_wr && wd[3])  r_underrun <= 1'b0;
      end
   end

   always_comb begin
      w_rd_nx = '0;
      case (w_sel)
         2'd0:    if (!w_empty) w_rd_nx = 32'(w_head);
         2'd1:    w_rd_nx = {16'd0, 8'(r_count), 3'd0, r_busy, r_underrun,
                             r_overflow, w_full, w_empty};
         2'd2:    w_rd_nx = {31'd0, r_enable};
         default: w_rd_nx = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_shreg   <= '0;
         r_div_cnt <= '0;
         r_bit_cnt <= '0;
         r_sclk    <= 1'b0;
         r_sdata   <= 1'b0;
         r_sfs     <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_state   <= w_state_nx;
         r_shreg   <= w_shreg_nx;
         r_div_cnt <= w_div_nx;
         r_bit_cnt <= w_bit_nx;
         r_sclk    <= w_sclk_nx;
         r_sdata   <= w_sdata_nx;
         r_sfs     <= w_sfs_nx;
         r_busy    <= w_busy_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_shreg_nx = r_shreg;
      w_div_nx   = r_div_cnt;
      w_bit_nx   = r_bit_cnt;
      w_sclk_nx  = r_sclk;
      w_sdata_nx = r_sdata;
      w_sfs_nx   = r_sfs;
      w_busy_nx  = r_busy;
      w_pop      = 1'b0;
      w_urun_set = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_edge && r_enable) begin
               w_pop      = !w_empty;
               w_urun_set = w_empty;
               w_shreg_nx = w_empty ? '0 : w_head;
               w_state_nx = SHIFT;
               w_div_nx   = '0;
               w_bit_nx   = '0;
               w_sclk_nx  = 1'b0;
               w_sdata_nx = w_shreg_nx[SAMPLE_W-1];
               w_sfs_nx   = 1'b1;
               w_busy_nx  = 1'b1;
            end
         end
         SHIFT: begin
            if (r_div_cnt == c_DIVW'(CLK_DIV - 1)) begin
               w_div_nx = '0;
               if (!r_sclk) begin
                  w_sclk_nx = 1'b1;
               end else if (r_bit_cnt == c_BW'(SAMPLE_W - 1)) begin
                  w_state_nx = IDLE;
                  w_sclk_nx  = 1'b0;
                  w_sdata_nx = 1'b0;
                  w_sfs_nx   = 1'b0;
                  w_busy_nx  = 1'b0;
               end else begin
                  // Falling sclk: advance to the next bit.
                  w_bit_nx   = r_bit_cnt + c_BW'(1);
                  w_sclk_nx  = 1'b0;
                  w_shreg_nx = r_shreg << 1;
                  w_sdata_nx = r_shreg[SAMPLE_W-2];
                  w_sfs_nx   = 1'b0;
               end
            end else begin
               w_div_nx = r_div_cnt + c_DIVW'(1);
            end
         end
         default: w_state_nx = IDLE;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_audio_serial_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_serial_tx
// Brief    : Scoreboard bench for audio_serial_tx (DEPTH=16, SAMPLE_W=16,
//            CLK_DIV=2): queued expected frames and register reads.
// Revision : 1.0  initial release
// ============================================================================
module tb_audio_serial_tx;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        we = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wd = '0;
   logic [31:0] rd;
   logic        request = 1'b0;
   logic        sclk, sdata, sfs, busy;

   int n_cmp = 0;
   int n_err = 0;

   logic [15:0] frame_q[$];
   logic [31:0] rd_q[$];
   string       rd_name_q[$];
   logic        rd_req = 1'b0;
   logic        rd_req_d = 1'b0;

   audio_serial_tx #(.DEPTH(16), .SAMPLE_W(16), .CLK_DIV(2)) dut (
      .clk(clk), .reset(reset), .we(we), .addr(addr), .wd(wd), .rd(rd),
      .request(request), .sclk(sclk), .sdata(sdata), .sfs(sfs), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rd_req_d <= rd_req;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: register read responses and serial frames.
   initial begin : monitor
      logic [15:0] bits;
      int          nbits, busy_cnt, sfs_cnt;
      logic        prev_sclk, prev_busy;
      logic [15:0] exp;
      bits = '0; nbits = 0; busy_cnt = 0; sfs_cnt = 0;
      prev_sclk = 1'b0; prev_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (rd_req_d) begin
            if (rd_q.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL rd_scoreboard: got read 0x%08h, expected nothing queued", rd);
            end else begin
               check(rd_name_q.pop_front(), rd, rd_q.pop_front());
            end
         end
         if (!reset) begin
            bits = '0; nbits = 0; busy_cnt = 0; sfs_cnt = 0;
            prev_sclk = 1'b0; prev_busy = 1'b0;
         end else begin
            if (busy) begin
               busy_cnt++;
               if (sfs) sfs_cnt++;
            end
            if (sclk && !prev_sclk) begin
               bits = {bits[14:0], sdata};
               nbits++;
            end
            if (prev_busy && !busy) begin
               if (frame_q.size() == 0) begin
                  n_cmp++; n_err++;
                  $display("FAIL unexpected_frame: got data 0x%04h, expected no frame", bits);
               end else begin
                  exp = frame_q.pop_front();
                  check("frame_data", 32'(bits), 32'(exp));
                  check("frame_bits", nbits, 16);
                  check("frame_busy_cycles", busy_cnt, 64);
                  check("frame_sfs_cycles", sfs_cnt, 4);
               end
               bits = '0; nbits = 0; busy_cnt = 0; sfs_cnt = 0;
            end
            prev_sclk = sclk;
            prev_busy = busy;
         end
      end
   end

   task automatic bus_write(logic [31:0] a, logic [31:0] d);
      @(negedge clk);
      we = 1'b1; addr = a; wd = d;
      @(negedge clk);
      we = 1'b0;
   endtask

   task automatic bus_read(logic [31:0] a, logic [31:0] exp, string name);
      @(negedge clk);
      addr = a; rd_req = 1'b1;
      rd_q.push_back(exp);
      rd_name_q.push_back(name);
      @(negedge clk);
      rd_req = 1'b0;
   endtask

   task automatic pulse_request();
      @(negedge clk);
      request = 1'b1;
      repeat (3) @(negedge clk);
      request = 1'b0;
   endtask

   task automatic wait_busy(logic level, int limit, string name);
      for (int i = 0; i < limit; i++) begin
         if (busy === level) return;
         @(negedge clk);
      end
      n_cmp++; n_err++;
      $display("FAIL %s: timeout, busy=%b, expected %b", name, busy, level);
   endtask

   task automatic run_frame(logic [15:0] exp);
      frame_q.push_back(exp);
      pulse_request();
      wait_busy(1'b1, 20, "frame_start");
      wait_busy(1'b0, 100, "frame_end");
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int busy_seen;
      // Reset
      repeat (2) @(negedge clk);
      check("outputs_in_reset", {28'd0, sclk, sdata, sfs, busy}, 32'd0);
      reset = 1'b1;
      @(negedge clk);
      check("outputs_after_reset", {28'd0, sclk, sdata, sfs, busy}, 32'd0);
      bus_read(32'h4, 32'h0000_0001, "status_reset");

      // Single frame
      bus_write(32'h8, 32'h1);
      bus_write(32'h0, 32'h0000_A5C3);
      bus_read(32'h0, 32'h0000_A5C3, "data_head");
      bus_read(32'h4, 32'h0000_0100, "status_one");
      bus_read(32'h8, 32'h0000_0001, "ctrl_enabled");
      run_frame(16'hA5C3);
      bus_read(32'h4, 32'h0000_0001, "status_after_frame");

      // Overflow
      for (int v = 1; v <= 17; v++) bus_write(32'h0, 32'(v));
      bus_read(32'h4, 32'h0000_1006, "status_overflow");
      run_frame(16'h0001);
      bus_read(32'h4, 32'h0000_0F04, "status_ovf_sticky");
      bus_write(32'h4, 32'h4);
      bus_read(32'h4, 32'h0000_0F00, "status_ovf_cleared");
      for (int v = 2; v <= 16; v++) run_frame(16'(v));
      bus_read(32'h4, 32'h0000_0001, "status_drained");

      // Underrun
      run_frame(16'h0000);
      bus_read(32'h4, 32'h0000_0009, "status_underrun");
      bus_write(32'h4, 32'h8);
      bus_read(32'h4, 32'h0000_0001, "status_urun_cleared");

      // Disabled: request ignored, nothing popped
      bus_write(32'h8, 32'h0);
      bus_write(32'h0, 32'h0000_1234);
      pulse_request();
      busy_seen = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (busy || sclk || sdata || sfs) busy_seen++;
      end
      check("disabled_outputs_quiet", busy_seen, 0);
      bus_read(32'h4, 32'h0000_0100, "status_disabled");
      bus_read(32'h0, 32'h0000_1234, "data_not_popped");
      bus_read(32'h8, 32'h0000_0000, "ctrl_disabled");
      bus_write(32'hC, 32'hFFFF_FFFF);
      bus_read(32'hC, 32'h0000_0000, "reserved_reads_zero");

      // Request during busy
      bus_write(32'h8, 32'h1);
      bus_write(32'h0, 32'h0000_5678);
      bus_write(32'h0, 32'h0000_9ABC);
      bus_read(32'h4, 32'h0000_0300, "status_three");
      frame_q.push_back(16'h1234);
      pulse_request();
      wait_busy(1'b1, 20, "busy_frame_start");
      repeat (6) @(negedge clk);
      pulse_request();
      repeat (6) @(negedge clk);
      pulse_request();
      wait_busy(1'b0, 100, "busy_frame_end");
      repeat (8) @(negedge clk);
      bus_read(32'h4, 32'h0000_0200, "status_one_pop");
      bus_read(32'h0, 32'h0000_5678, "data_next_head");

      // Reset mid-frame
      pulse_request();
      wait_busy(1'b1, 20, "abort_frame_start");
      repeat (28) @(negedge clk);
      check("busy_before_reset", {31'd0, busy}, 32'd1);
      #1 reset = 1'b0;
      #1 check("reset_async_outputs", {28'd0, sclk, sdata, sfs, busy}, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      bus_read(32'h4, 32'h0000_0001, "status_after_abort");
      bus_read(32'h8, 32'h0000_0000, "ctrl_after_abort");

      repeat (4) @(negedge clk);
      check("frames_outstanding", frame_q.size(), 0);
      check("reads_outstanding", rd_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
